// File: rtl/data_mem_responder.sv
// Data-side load/store responder: byte-lane word RAM plus a 16-byte MMIO window
// (64-bit cycle timer with tear-free high-word snapshot, sticky error status, scratch).
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        access_ram_read,
  input  logic [31:0] access_ram_raddr,
  output logic [31:0] access_ram_rdata,
  input  logic        access_ram_write,
  input  logic [31:0] access_ram_waddr,
  input  logic [31:0] access_ram_wdata,
  input  logic [1:0]  access_ram_write_width,
  output logic        err_irq
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

  function automatic logic is_ram(input logic [31:0] addr);
    return (addr >> TAG_LSB) == (RAM_BASE >> TAG_LSB);
  endfunction

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:4] == MMIO_BASE[31:4];
  endfunction

  logic                  rd_ram, rd_mmio, rd_unmapped, rd_mtime_lo;
  logic                  wr_reserved, wr_misaligned, wr_unmapped, wr_legal;
  logic                  ram_we, mmio_wr;
  logic [3:0]            lane_be;
  logic [31:0]           lane_wdata;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic [7:0]            rd_lane [4];
  logic [31:0]           ram_rdata;

  logic [63:0] mtime_reg;
  logic [31:0] hi_snap_reg;
  logic [31:0] scratch_reg;
  logic [2:0]  status_reg, status_next, status_set, status_clr;

  // Sub-word address bits are consumed by the core, not here.
  logic unused_raddr_bits;
  assign unused_raddr_bits = ^access_ram_raddr[1:0];

  assign rd_idx = access_ram_raddr[TAG_LSB-1:2];
  assign wr_idx = access_ram_waddr[TAG_LSB-1:2];

  always_comb begin
    rd_ram      = access_ram_read && is_ram(access_ram_raddr);
    rd_mmio     = access_ram_read && is_mmio(access_ram_raddr);
    rd_unmapped = access_ram_read && !is_ram(access_ram_raddr) && !is_mmio(access_ram_raddr);
    rd_mtime_lo = rd_mmio && (access_ram_raddr[3:2] == 2'b00);

    wr_reserved   = access_ram_write && (access_ram_write_width == 2'b11);
    wr_misaligned = access_ram_write &&
                    (((access_ram_write_width == 2'b01) && access_ram_waddr[0]) ||
                     ((access_ram_write_width == 2'b10) && (access_ram_waddr[1:0] != 2'b00)));
    wr_unmapped   = access_ram_write && !is_ram(access_ram_waddr) && !is_mmio(access_ram_waddr);
    wr_legal      = access_ram_write && !rst_sync && !wr_reserved && !wr_misaligned;
    ram_we        = wr_legal && is_ram(access_ram_waddr);
    // Only aligned full-word stores reach the MMIO registers.
    mmio_wr       = wr_legal && is_mmio(access_ram_waddr) && (access_ram_write_width == 2'b10);
  end

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = access_ram_wdata;
    case (access_ram_write_width)
      2'b00: begin
        lane_be    = 4'b0001 << access_ram_waddr[1:0];
        lane_wdata = {4{access_ram_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = access_ram_waddr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{access_ram_wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = access_ram_wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (ram_we && lane_be[gi]) begin
          mem[wr_idx] <= lane_wdata[gi*8 +: 8];
        end
      end

      assign rd_lane[gi] = mem[rd_idx];
    end
  endgenerate

  assign ram_rdata = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};

  always_comb begin
    access_ram_rdata = '0;
    if (rd_ram) begin
      access_ram_rdata = ram_rdata;
    end else if (rd_mmio) begin
      case (access_ram_raddr[3:2])
        2'b00:   access_ram_rdata = mtime_reg[31:0];
        2'b01:   access_ram_rdata = hi_snap_reg;
        2'b10:   access_ram_rdata = {29'd0, status_reg};
        default: access_ram_rdata = scratch_reg;
      endcase
    end
  end

  // A set event outranks a same-cycle write-1-to-clear of that bit.
  always_comb begin
    status_set  = {wr_reserved, wr_unmapped | rd_unmapped, wr_misaligned};
    status_clr  = (mmio_wr && (access_ram_waddr[3:2] == 2'b10)) ? access_ram_wdata[2:0] : 3'b000;
    status_next = (status_reg & ~status_clr) | status_set;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      mtime_reg   <= '0;
      hi_snap_reg <= '0;
      status_reg  <= '0;
      scratch_reg <= '0;
    end else begin
      mtime_reg  <= mtime_reg + 64'd1;
      status_reg <= status_next;
      if (rd_mtime_lo) begin
        hi_snap_reg <= mtime_reg[63:32];
      end
      if (mmio_wr && (access_ram_waddr[3:2] == 2'b11)) begin
        scratch_reg <= access_ram_wdata;
      end
    end
  end

  assign err_irq = |status_reg;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-side memory responder for the pipelined RV32 core's load/store port.
- Sits on the core's access_ram_* interface and serves loads and stores.
- Contains a word-organised RAM with byte/halfword/word store lanes, plus a small MMIO block: free-running 64-bit cycle timer, sticky error status, scratch register.
- Loads return data in the same cycle (the core consumes read data in EX); stores commit at the clock edge.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words (default 4096 words = 16 KiB).
- RAM_BASE, 32'h0000_0000, byte base address of the RAM; aligned to 2^(DEPTH_LOG2+2).
- MMIO_BASE, 32'h1000_0000, byte base of the 16-byte MMIO window; aligned to 16.

Ports:
- clk  in  1  core clock
- rst_sync  in  1  synchronous reset, active-high
- access_ram_read  in  1  load request, valid this cycle
- access_ram_raddr  in  32  load byte address
- access_ram_rdata  out  32  load data, combinational
- access_ram_write  in  1  store request, committed at next rising edge
- access_ram_waddr  in  32  store byte address
- access_ram_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- access_ram_write_width  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- err_irq  out  1  OR of status[2:0]

Behaviour:
- Decode, applied to each address independently:
  - RAM hit: addr[31:DEPTH_LOG2+2] == RAM_BASE[31:DEPTH_LOG2+2].
  - MMIO hit: addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
- Reads (combinational, zero latency):
  - access_ram_read=0: rdata = 0.
  - RAM hit: the full aligned word at addr[DEPTH_LOG2+1:2]. addr[1:0] is ignored; the core extracts sub-words.
  - MMIO offsets:
    - 0x0 mtime_lo
    - 0x4 hi_snap
    - 0x8 status (zero-extended)
    - 0xC scratch
  - Unmapped read: rdata = 0; set status[1] at the edge.
- Read/write collision: a read and a write to the same word in one cycle returns the OLD data. No write forwarding.
- Writes (only when access_ram_write=1 and rst_sync=0, at the rising edge):
  - Byte: lane waddr[1:0] gets wdata[7:0].
  - Halfword: lanes {waddr[1],0}, which must be 0 or 2, get wdata[15:0].
  - Word: the whole word gets wdata.
  - Misaligned store (half with waddr[0]=1, or word with waddr[1:0]!=0): no state change; set status[0].
  - Width 11: no state change; set status[2].
  - Unmapped store: no state change; set status[1].
- MMIO write rules (only aligned word writes are honoured; sub-word MMIO writes are ignored, no error):
  - 0x0 and 0x4: ignored.
  - 0x8: write-1-to-clear status[2:0].
  - 0xC: scratch <= wdata.
- mtime: 64-bit counter, +1 every cycle when not in reset, wraps from 2^64-1 to 0.
- hi_snap:
  - A read of 0x0 latches mtime[63:32] into hi_snap at the same edge.
  - The value captured is the same-cycle mtime value, consistent with the lo word returned in that cycle.
  - A read of 0x4 returns hi_snap, so lo-then-hi read pairs are tear-free.
- Status set/clear precedence: a set event in the same cycle as a W1C of that bit leaves the bit SET.
- Reset (rst_sync=1 at an edge) clears: mtime, hi_snap, status, scratch.
  - RAM contents are not reset; they are retained across reset.
  - Any write presented during reset is discarded.
  - Reads remain combinational during reset.
- Output reset values: access_ram_rdata = 0 when no read is requested; err_irq = 0.
- No stall or back-pressure. Every request completes in its cycle.

Test Plan:
- Byte-lane stores: word write 0x11223344 @0x40, then byte 0xAA @0x41 and half 0xBEEF @0x42 → read @0x40 returns 0xBEEFAA44; err_irq=0.
- Misaligned and reserved widths: word write 0xDEADBEEF @0x46 → RAM@0x44 unchanged, status=0x1, err_irq=1. Then width 11 @0x48 → status=0x5. Then write 0x5 to MMIO 0x1000_0008 → status=0, err_irq=0.
- Set vs clear in one cycle: unmapped load @0x2000_0000 issued in the same cycle as a W1C of 0x2 to status → rdata=0, status[1]=1 afterwards.
- Timer coherence: reset, release, hold 5 cycles, read 0x1000_0000 → 0x5 (counts from first non-reset edge). Preload test with mtime near 0x0000_0000_FFFF_FFFF: read lo=0xFFFFFFFF, next-cycle read hi=0x0 (snapshot, not live 0x1).
- Collision: word write 0x12345678 and read of the same address in one cycle → rdata = old value; read next cycle → 0x12345678.
- Reset mid-operation: scratch=0xCAFEF00D, RAM@0x10=0x55; assert rst_sync with a word write 0x99 @0x10 → scratch=0, RAM@0x10 still 0x55, mtime=0.
